canny_frame_ctrl: RTL

CANNY_FRAME_CTRL -- requirements
Module: canny_frame_ctrl

---
 rtl/canny_frame_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for a Canny edge datapath: counts pixel coordinates, strobes the datapath,
// drains the pipeline at end of frame and tracks output validity. Define CANNY_CROP_EN to crop BORDER pixels.
module canny_frame_ctrl #(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 512,
   parameter int BORDER   = 4,
   parameter int PIPE_LAT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        dp_en,
   output logic [15:0] col,
   output logic [15:0] row,
   output logic        out_valid,
   output logic        out_last,
   output logic        busy,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [15:0] COL_MAX   = 16'(IMG_W - 1);
   localparam logic [15:0] ROW_MAX   = 16'(IMG_H - 1);
   localparam logic [15:0] DRAIN_MAX = 16'(PIPE_LAT - 1);
`ifdef CANNY_CROP_EN
   localparam logic [15:0] C_LO   = 16'(BORDER);
   localparam logic [15:0] C_HI   = 16'(IMG_W - 1 - BORDER);
   localparam logic [15:0] R_LO   = 16'(BORDER);
   localparam logic [15:0] R_HI   = 16'(IMG_H - 1 - BORDER);
   localparam logic [15:0] LAST_C = C_HI;
   localparam logic [15:0] LAST_R = R_HI;
`else
   localparam logic [15:0] LAST_C = COL_MAX;
   localparam logic [15:0] LAST_R = ROW_MAX;
`endif

   state_t              state, state_nxt;
   logic [15:0]         drain_cnt;
   logic                accept;
   logic                last_pix;
   logic                crop_ok;
   logic [PIPE_LAT-1:0] dl_vld;
   logic [15:0]         dl_col [PIPE_LAT];
   logic [15:0]         dl_row [PIPE_LAT];
   logic [15:0]         lc, lr;

   assign accept   = in_valid & in_ready;
   assign last_pix = (col == COL_MAX) && (row == ROW_MAX);

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      dp_en      = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            dp_en    = in_valid;
            if (in_valid && last_pix) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy  = 1'b1;
            dp_en = 1'b1;
            if (drain_cnt == DRAIN_MAX) state_nxt = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         drain_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
         end
         if (accept) begin
            if (col == COL_MAX) begin
               col <= '0;
               row <= row + 16'd1;
            end else begin
               col <= col + 16'd1;
            end
         end
         if (state == DRAIN) drain_cnt <= drain_cnt + 16'd1;
      end
   end

   // Delay line: valid bits are control and reset; coordinates are data and do not.
   always_ff @(posedge clk) begin
      if (rst) begin
         dl_vld <= '0;
      end else if (dp_en) begin
         dl_vld[0] <= accept;
         for (int i = 1; i < PIPE_LAT; i++) dl_vld[i] <= dl_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (dp_en) begin
         dl_col[0] <= col;
         dl_row[0] <= row;
         for (int i = 1; i < PIPE_LAT; i++) begin
            dl_col[i] <= dl_col[i-1];
            dl_row[i] <= dl_row[i-1];
         end
      end
   end

   assign lc = dl_col[PIPE_LAT-1];
   assign lr = dl_row[PIPE_LAT-1];

`ifdef CANNY_CROP_EN
   assign crop_ok = (lc >= C_LO) && (lc <= C_HI) && (lr >= R_LO) && (lr <= R_HI);
`else
   assign crop_ok = 1'b1;
`endif

   assign out_valid = dp_en & dl_vld[PIPE_LAT-1] & crop_ok;
   assign out_last  = out_valid && (lc == LAST_C) && (lr == LAST_R);

endmodule
